bus_arbiter: RTL

Two-port to one-port memory bus arbiter placed between `hkr_mips` and the shared system memory/peripheral bus. It accepts the CPU's independent instruction bus (ibus) and data bus (dbus) requests, serialises them onto a single waitrequest-style memory port, and drives `ibus_stall`/`dbus_stall` back to the core until each transfer completes. It also provides a wait-state watchdog and an optional one-entry instruction fetch buffer.

---
 rtl/hkr_bus_pkg.sv | 21 ++
 rtl/bus_arb_fetch_buf.sv | 42 ++++
 rtl/bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hkr_bus_pkg.sv
// Shared types and constants for the hkr_mips two-port to one-port bus arbiter.
package hkr_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } bus_state_t;

  localparam logic [31:0] BUS_TIMEOUT_DATA = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic        write;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_fetch_buf.sv
// One-entry instruction fetch buffer: word tag, data and valid, with hit and
// write-invalidate logic. Only instantiated when BUS_ARB_IFETCH_BUF_EN is defined.
module bus_arb_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_word,
  input  logic [3:0]  lookup_byte_en,
  input  logic        lookup_read,
  input  logic        pend_wr,
  input  logic [29:0] pend_word,
  input  logic        fill,
  input  logic        inval,
  input  logic [29:0] mem_word,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] hit_data
);

  logic [29:0] tag;
  logic [31:0] data;
  logic        valid;

  // A pending dbus write to the same word would make the buffered copy stale.
  assign hit = valid && lookup_read && (&lookup_byte_en) && (tag == lookup_word)
               && !(pend_wr && (pend_word == lookup_word));
  assign hit_data = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= mem_word;
      data  <= fill_data;
      valid <= 1'b1;
    end else if (inval && (mem_word == tag)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises hkr_mips ibus/dbus requests onto one waitrequest-style memory port,
// with a wait-state watchdog. Optional fetch buffer: define BUS_ARB_IFETCH_BUF_EN.
module bus_arbiter
  import hkr_bus_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_addr,
  input  logic [3:0]  ibus_byte_en,
  input  logic        ibus_read,
  input  logic        ibus_write,
  input  logic [31:0] ibus_write_data,
  output logic [31:0] ibus_read_data,
  output logic        ibus_stall,
  input  logic [31:0] dbus_addr,
  input  logic [3:0]  dbus_byte_en,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_write_data,
  output logic [31:0] dbus_read_data,
  output logic        dbus_stall,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_waitrequest,
  output logic        bus_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 2);

  bus_state_t  state, state_nxt;
  bus_req_t    req_sel;
  logic        req_i, req_d, grant_i, own_req, busy, wd_expire;
  logic        issue, hit_take, mem_done, timeout, load_i, load_d;
  logic [31:0] load_data;
  logic        last_grant_d;
  logic [CW-1:0] wait_cnt;
  logic        buf_hit;
  logic [31:0] buf_data;

  assign req_i = ibus_read | ibus_write;
  assign req_d = dbus_read | dbus_write;
  assign ibus_stall = req_i && (state != DONE_I);
  assign dbus_stall = req_d && (state != DONE_D);

  // Under contention the port not granted last time wins.
  assign grant_i = req_i && (!req_d || last_grant_d);
  assign req_sel = grant_i
    ? '{addr: ibus_addr, byte_en: ibus_byte_en, write: ibus_write, wdata: ibus_write_data}
    : '{addr: dbus_addr, byte_en: dbus_byte_en, write: dbus_write, wdata: dbus_write_data};

  assign busy      = (state == BUSY_I) || (state == BUSY_D);
  assign own_req   = (state == BUSY_D) ? req_d : req_i;
  assign wd_expire = (MAX_WAIT != 0) && busy && mem_waitrequest
                     && (wait_cnt == CW'(MAX_WAIT - 1));

`ifdef BUS_ARB_IFETCH_BUF_EN
  bus_arb_fetch_buf u_fetch_buf (
    .clk            (clk),
    .rst            (rst),
    .lookup_word    (ibus_addr[31:2]),
    .lookup_byte_en (ibus_byte_en),
    .lookup_read    (ibus_read && !ibus_write),
    .pend_wr        (dbus_write),
    .pend_word      (dbus_addr[31:2]),
    .fill           ((state == BUSY_I) && mem_read && !mem_waitrequest),
    .inval          (mem_write && !mem_waitrequest),
    .mem_word       (mem_addr[31:2]),
    .fill_data      (mem_read_data),
    .hit            (buf_hit),
    .hit_data       (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    hit_take  = 1'b0;
    mem_done  = 1'b0;
    timeout   = 1'b0;
    load_i    = 1'b0;
    load_d    = 1'b0;
    load_data = mem_read_data;
    case (state)
      IDLE: begin
        if (grant_i && buf_hit) begin
          state_nxt = DONE_I;
          hit_take  = 1'b1;
          load_i    = 1'b1;
          load_data = buf_data;
        end else if (grant_i) begin
          state_nxt = BUSY_I;
          issue     = 1'b1;
        end else if (req_d) begin
          state_nxt = BUSY_D;
          issue     = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (!mem_waitrequest || wd_expire) begin
          mem_done = !mem_waitrequest;
          timeout  = mem_waitrequest;
          // A withdrawn request (pipeline flush) discards the result.
          if (own_req) begin
            state_nxt = (state == BUSY_I) ? DONE_I : DONE_D;
            load_i    = mem_read && (state == BUSY_I);
            load_d    = mem_read && (state == BUSY_D);
            if (mem_waitrequest) load_data = BUS_TIMEOUT_DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DONE_I, DONE_D: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mem_addr       <= '0;
      mem_byte_en    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      ibus_read_data <= '0;
      dbus_read_data <= '0;
      bus_timeout    <= 1'b0;
      last_grant_d   <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      state       <= state_nxt;
      bus_timeout <= timeout;
      if (issue) begin
        mem_addr       <= req_sel.addr;
        mem_byte_en    <= req_sel.byte_en;
        mem_write_data <= req_sel.wdata;
        mem_write      <= req_sel.write;
        mem_read       <= !req_sel.write;
        last_grant_d   <= !grant_i;
        wait_cnt       <= '0;
      end else if (mem_done || timeout) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end else if (busy && mem_waitrequest && (wait_cnt != CW'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (hit_take) last_grant_d <= 1'b0;
      if (load_i) ibus_read_data <= load_data;
      if (load_d) dbus_read_data <= load_data;
    end
  end

endmodule
